// File: rtl/collatz_seq.sv
// Collatz sequence iterator: steps a start value to 1 and reports step count, peak and termination code.
// Optional macro COLLATZ_PEAK_EN enables the peak tracker; otherwise peak is tied to zero.
module collatz_seq #(
   parameter int WIDTH     = 32,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 go,
   input  logic [WIDTH-1:0]     n,
   output logic                 busy,
   output logic                 done,
   output logic [WIDTH-1:0]     dout,
   output logic [CNT_WIDTH-1:0] steps,
   output logic [WIDTH-1:0]     peak,
   output logic [1:0]           status
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam logic [WIDTH-1:0]     VAL_ZERO   = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0]     VAL_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH+1:0]     TRIPLE_ONE = {{(WIDTH+1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] CNT_ZERO   = {CNT_WIDTH{1'b0}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};
   localparam logic [1:0]           ST_ONE     = 2'b00;
   localparam logic [1:0]           ST_OVF     = 2'b01;
   localparam logic [1:0]           ST_ZERO    = 2'b10;
   localparam logic [1:0]           ST_LIMIT   = 2'b11;

   state_t                 state;
   state_t                 state_nx;
   logic [WIDTH-1:0]       dout_nx;
   logic [CNT_WIDTH-1:0]   steps_nx;
   logic [1:0]             status_nx;
   logic [WIDTH+1:0]       triple;
   logic [WIDTH-1:0]       step_val;
   logic                   ovf;
   logic                   load;
   logic                   upd;

   // 3*dout+1 is formed two bits wider so overflow is visible in the top bits
   assign triple   = {2'b00, dout} + {1'b0, dout, 1'b0} + TRIPLE_ONE;
   assign ovf      = dout[0] && (triple[WIDTH+1:WIDTH] != 2'b00);
   assign step_val = dout[0] ? triple[WIDTH-1:0] : {1'b0, dout[WIDTH-1:1]};

   assign busy = (state == RUN);
   assign done = (state == DONE);

   // Next-state and datapath selection
   always_comb begin
      state_nx  = state;
      dout_nx   = dout;
      steps_nx  = steps;
      status_nx = status;
      load      = 1'b0;
      upd       = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (go) begin
               load      = 1'b1;
               dout_nx   = n;
               steps_nx  = CNT_ZERO;
               status_nx = ST_ONE;
               if (n == VAL_ONE) begin
                  state_nx = DONE;
               end else if (n == VAL_ZERO) begin
                  state_nx  = DONE;
                  status_nx = ST_ZERO;
               end else begin
                  state_nx = RUN;
               end
            end else begin
               state_nx = state;
            end
         end
         RUN: begin
            // Overflow wins over the step limit; both leave the datapath untouched
            if (ovf) begin
               state_nx  = DONE;
               status_nx = ST_OVF;
            end else if (step_val == VAL_ONE) begin
               upd       = 1'b1;
               dout_nx   = step_val;
               steps_nx  = steps + CNT_ONE;
               state_nx  = DONE;
               status_nx = ST_ONE;
            end else if (steps == CNT_MAX) begin
               state_nx  = DONE;
               status_nx = ST_LIMIT;
            end else begin
               upd      = 1'b1;
               dout_nx  = step_val;
               steps_nx = steps + CNT_ONE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         dout   <= VAL_ZERO;
         steps  <= CNT_ZERO;
         status <= ST_ONE;
      end else begin
         state  <= state_nx;
         dout   <= dout_nx;
         steps  <= steps_nx;
         status <= status_nx;
      end
   end

`ifdef COLLATZ_PEAK_EN
   logic [WIDTH-1:0] peak_nx;

   // Running maximum of every value dout takes in the run
   always_comb begin
      peak_nx = peak;
      if (load) begin
         peak_nx = n;
      end else if (upd && (step_val > peak)) begin
         peak_nx = step_val;
      end else begin
         peak_nx = peak;
      end
   end

   // Peak register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         peak <= VAL_ZERO;
      end else begin
         peak <= peak_nx;
      end
   end
`else
   assign peak = VAL_ZERO;
`endif

endmodule

// File: tb/tb_collatz_seq.sv
// Self-checking bench for collatz_seq: three instances (default, 8-bit value, 4-bit counter)
// compared against a plain-arithmetic Collatz model.
module tb_collatz_seq;

   localparam int BOUND = 3000;

   logic        clk = 1'b0;
   logic        reset;
   logic        go_a, go_b, go_c;
   logic [31:0] n_a, n_c;
   logic [7:0]  n_b;

   logic        busy_a, done_a, busy_b, done_b, busy_c, done_c;
   logic [31:0] dout_a, peak_a, dout_c, peak_c;
   logic [7:0]  dout_b, peak_b;
   logic [15:0] steps_a, steps_b;
   logic [3:0]  steps_c;
   logic [1:0]  status_a, status_b, status_c;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   collatz_seq #(.WIDTH(32), .CNT_WIDTH(16)) dut_a (
      .clk(clk), .reset(reset), .go(go_a), .n(n_a), .busy(busy_a), .done(done_a),
      .dout(dout_a), .steps(steps_a), .peak(peak_a), .status(status_a));

   collatz_seq #(.WIDTH(8), .CNT_WIDTH(16)) dut_b (
      .clk(clk), .reset(reset), .go(go_b), .n(n_b), .busy(busy_b), .done(done_b),
      .dout(dout_b), .steps(steps_b), .peak(peak_b), .status(status_b));

   collatz_seq #(.WIDTH(32), .CNT_WIDTH(4)) dut_c (
      .clk(clk), .reset(reset), .go(go_c), .n(n_c), .busy(busy_c), .done(done_c),
      .dout(dout_c), .steps(steps_c), .peak(peak_c), .status(status_c));

   // Reference: iterate the sequence with wide arithmetic; cyc counts clock edges from go to done
   task automatic model(input longint unsigned nv, input int w, input int cw,
                        output longint unsigned d, output longint unsigned s,
                        output longint unsigned p, output int st, output int cyc);
      longint unsigned vmax = (64'd1 << w) - 64'd1;
      longint unsigned smax = (64'd1 << cw) - 64'd1;
      longint unsigned nx;
      bit fin = 1'b0;
      d = nv; p = nv; s = 0; st = 0; cyc = 1;
      if (nv == 0) st = 2;
      else if (nv != 1) begin
         while (!fin) begin
            cyc++;
            nx = (d % 2 == 1) ? 3 * d + 1 : d / 2;
            if (nx > vmax) begin st = 1; fin = 1'b1; end
            else if (nx == 1) begin d = 1; s++; if (nx > p) p = nx; fin = 1'b1; end
            else if (s == smax) begin st = 3; fin = 1'b1; end
            else begin d = nx; s++; if (nx > p) p = nx; end
         end
      end
`ifndef COLLATZ_PEAK_EN
      p = 0;
`endif
   endtask

   task automatic snap(input int which, output longint unsigned d, output longint unsigned s,
                       output longint unsigned p, output int st, output bit bz, output bit dn);
      case (which)
         0: begin d = 64'(dout_a); s = 64'(steps_a); p = 64'(peak_a); st = int'(status_a); bz = busy_a; dn = done_a; end
         1: begin d = 64'(dout_b); s = 64'(steps_b); p = 64'(peak_b); st = int'(status_b); bz = busy_b; dn = done_b; end
         default: begin d = 64'(dout_c); s = 64'(steps_c); p = 64'(peak_c); st = int'(status_c); bz = busy_c; dn = done_c; end
      endcase
   endtask

   function automatic bit done_of(input int which);
      case (which)
         0: return done_a;
         1: return done_b;
         default: return done_c;
      endcase
   endfunction

   task automatic start(input int which, input longint unsigned nv);
      @(negedge clk);
      case (which)
         0: begin n_a = nv[31:0]; go_a = 1'b1; end
         1: begin n_b = nv[7:0]; go_b = 1'b1; end
         default: begin n_c = nv[31:0]; go_c = 1'b1; end
      endcase
      @(posedge clk); #1;
      go_a = 1'b0; go_b = 1'b0; go_c = 1'b0;
   endtask

   task automatic wait_done(input int which, inout int cyc, output bit to);
      while (!done_of(which) && cyc < BOUND) begin
         @(posedge clk); #1;
         cyc++;
      end
      to = !done_of(which);
   endtask

   task automatic test_reset();
      longint unsigned d, s, p; int st; bit bz, dn;
      for (int i = 0; i < 3; i++) begin
         snap(i, d, s, p, st, bz, dn);
         checks++;
         if ({bz, dn} !== 2'b00 || d !== 64'd0 || s !== 64'd0 || p !== 64'd0 || st !== 0) begin
            errors++;
            $display("FAIL reset_state inst %0d got busy=%0b done=%0b dout=%0d steps=%0d peak=%0d status=%0d expected all 0",
                     i, bz, dn, d, s, p, st);
         end
      end
   endtask

   // Spec scenarios: nominal, trivial inputs, overflow, step limit
   task automatic test_directed();
      int which_t[6] = '{0, 0, 0, 1, 2, 0};
      longint unsigned n_t[6] = '{27, 1, 0, 27, 27, 6};
      int wid_t[6] = '{32, 32, 32, 8, 32, 32};
      int cw_t[6] = '{16, 16, 16, 16, 4, 16};
      longint unsigned d, s, p, ed, es, ep; int st, est, cyc, ecyc; bit bz, dn, to;
      for (int i = 0; i < 6; i++) begin
         model(n_t[i], wid_t[i], cw_t[i], ed, es, ep, est, ecyc);
         start(which_t[i], n_t[i]);
         cyc = 1;
         wait_done(which_t[i], cyc, to);
         snap(which_t[i], d, s, p, st, bz, dn);
         checks++;
         if (to) begin errors++; $display("FAIL directed_timeout n=%0d got no done expected done", n_t[i]); end
         checks++;
         if (cyc !== ecyc) begin errors++; $display("FAIL directed_latency n=%0d got %0d expected %0d", n_t[i], cyc, ecyc); end
         checks++;
         if (d !== ed || s !== es || p !== ep || st !== est || bz !== 1'b0) begin
            errors++;
            $display("FAIL directed_result n=%0d inst %0d got dout=%0d steps=%0d peak=%0d status=%0d busy=%0b expected %0d %0d %0d %0d 0",
                     n_t[i], which_t[i], d, s, p, st, bz, ed, es, ep, est);
         end
      end
      // Anchor the model itself to the published figures
      model(27, 32, 16, ed, es, ep, est, ecyc);
      checks++;
      if (ecyc !== 112 || es !== 111 || ed !== 1 || est !== 0) begin errors++; $display("FAIL model_nominal got cyc=%0d steps=%0d expected 112 111", ecyc, es); end
      model(27, 8, 16, ed, es, ep, est, ecyc);
      checks++;
      if (ed !== 107 || es !== 11 || est !== 1) begin errors++; $display("FAIL model_overflow got dout=%0d steps=%0d expected 107 11", ed, es); end
      model(27, 32, 4, ed, es, ep, est, ecyc);
      checks++;
      if (es !== 15 || est !== 3) begin errors++; $display("FAIL model_limit got steps=%0d status=%0d expected 15 3", es, est); end
   endtask

   task automatic test_go_during_run();
      longint unsigned d, s, p, ed, es, ep; int st, est, cyc, ecyc; bit bz, dn, to;
      model(27, 32, 16, ed, es, ep, est, ecyc);
      start(0, 27);
      cyc = 1;
      while (cyc < 10) begin @(posedge clk); #1; cyc++; end
      @(negedge clk); n_a = 32'd6; go_a = 1'b1;
      @(posedge clk); #1; go_a = 1'b0; cyc++;
      wait_done(0, cyc, to);
      snap(0, d, s, p, st, bz, dn);
      checks++;
      if (to || cyc !== ecyc || d !== ed || s !== es || p !== ep || st !== est) begin
         errors++;
         $display("FAIL go_during_run got cyc=%0d dout=%0d steps=%0d peak=%0d status=%0d expected %0d %0d %0d %0d %0d",
                  cyc, d, s, p, st, ecyc, ed, es, ep, est);
      end
   endtask

   task automatic test_reset_mid_run();
      longint unsigned d, s, p, ep; int st, cyc; bit bz, dn, to;
      start(0, 27);
      cyc = 1;
      while (cyc < 50) begin @(posedge clk); #1; cyc++; end
      @(negedge clk); #1; reset = 1'b1; #1;
      snap(0, d, s, p, st, bz, dn);
      checks++;
      if ({bz, dn} !== 2'b00 || d !== 64'd0 || s !== 64'd0 || p !== 64'd0 || st !== 0) begin
         errors++;
         $display("FAIL reset_mid_run got busy=%0b done=%0b dout=%0d steps=%0d peak=%0d status=%0d expected all 0", bz, dn, d, s, p, st);
      end
      @(negedge clk); reset = 1'b0;
      start(0, 6);
      cyc = 1;
      wait_done(0, cyc, to);
      snap(0, d, s, p, st, bz, dn);
`ifdef COLLATZ_PEAK_EN
      ep = 16;
`else
      ep = 0;
`endif
      checks++;
      if (to || d !== 64'd1 || s !== 64'd8 || p !== ep || st !== 0) begin
         errors++;
         $display("FAIL after_reset_run got dout=%0d steps=%0d peak=%0d status=%0d expected 1 8 %0d 0", d, s, p, st, ep);
      end
   endtask

   task automatic test_back_to_back();
      longint unsigned d, s, p, d0, s0, p0; int st, st0, cyc; bit bz, dn, to;
      // Outputs hold in DONE while go stays low
      snap(0, d0, s0, p0, st0, bz, dn);
      repeat (5) @(posedge clk);
      #1;
      snap(0, d, s, p, st, bz, dn);
      checks++;
      if (!dn || d !== d0 || s !== s0 || p !== p0 || st !== st0) begin
         errors++;
         $display("FAIL done_hold got done=%0b dout=%0d steps=%0d expected 1 %0d %0d", dn, d, s, d0, s0);
      end
      @(negedge clk); n_a = 32'd6; go_a = 1'b1;
      @(posedge clk); #1;
      cyc = 1;
      snap(0, d, s, p, st, bz, dn);
      checks++;
      if (!bz || d !== 64'd6 || s !== 64'd0) begin
         errors++;
         $display("FAIL restart_from_done got busy=%0b dout=%0d steps=%0d expected 1 6 0", bz, d, s);
      end
      wait_done(0, cyc, to);
      checks++;
      if (to || cyc !== 9) begin errors++; $display("FAIL held_go_latency got %0d expected 9", cyc); end
      @(posedge clk); #1;
      snap(0, d, s, p, st, bz, dn);
      checks++;
      if (!bz || dn || d !== 64'd6 || s !== 64'd0) begin
         errors++;
         $display("FAIL held_go_restart got busy=%0b done=%0b dout=%0d steps=%0d expected 1 0 6 0", bz, dn, d, s);
      end
      go_a = 1'b0;
      cyc = 2;
      wait_done(0, cyc, to);
   endtask

   task automatic test_random();
      longint unsigned nv, d, s, p, ed, es, ep; int st, est, cyc, ecyc, which, w, cw; bit bz, dn, to;
      for (int i = 0; i < 45; i++) begin
         which = (i < 20) ? 0 : (i < 35) ? 1 : 2;
         case (which)
            0: begin nv = 64'($urandom_range(2, 3000)); w = 32; cw = 16; end
            1: begin nv = 64'($urandom_range(0, 255)); w = 8; cw = 16; end
            default: begin nv = 64'($urandom_range(2, 100000)); w = 32; cw = 4; end
         endcase
         model(nv, w, cw, ed, es, ep, est, ecyc);
         start(which, nv);
         cyc = 1;
         wait_done(which, cyc, to);
         snap(which, d, s, p, st, bz, dn);
         checks++;
         if (to || cyc !== ecyc || d !== ed || s !== es || p !== ep || st !== est) begin
            errors++;
            $display("FAIL random inst %0d n=%0d got cyc=%0d dout=%0d steps=%0d peak=%0d status=%0d expected %0d %0d %0d %0d %0d",
                     which, nv, cyc, d, s, p, st, ecyc, ed, es, ep, est);
         end
      end
   endtask

   initial begin
      reset = 1'b1; go_a = 1'b0; go_b = 1'b0; go_c = 1'b0;
      n_a = 32'd0; n_b = 8'd0; n_c = 32'd0;
      #2;
      test_reset();
      @(negedge clk); reset = 1'b0;
      test_directed();
      test_go_during_run();
      test_reset_mid_run();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/collatz_seq.md
COLLATZ_SEQ -- requirements
Module: collatz_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: iteration value width in bits (minimum 4).
REQ-002 The block SHALL have parameter CNT_WIDTH, default 16: step counter width in bits (minimum 2).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port go, input, 1 bit: start request; n is sampled only on an accepted go.
REQ-006 The block SHALL have port n, input, WIDTH bits: start value.
REQ-007 The block SHALL have port busy, output, 1 bit: high while iterating.
REQ-008 The block SHALL have port done, output, 1 bit: high when a run has terminated; results valid.
REQ-009 The block SHALL have port dout, output, WIDTH bits: current iteration value.
REQ-010 The block SHALL have port steps, output, CNT_WIDTH bits: iterations performed in the current run.
REQ-011 The block SHALL have port peak, output, WIDTH bits: largest dout value seen in the current run.
REQ-012 The block SHALL have port status, output, 2 bits: termination code. 00 = reached 1; 01 = overflow; 10 = zero input; 11 = step limit.

Function
REQ-013 The block SHALL implement FSM states IDLE, RUN and DONE; busy = (state==RUN); done = (state==DONE).
REQ-014 go SHALL be accepted in IDLE or DONE and SHALL be ignored in RUN.
REQ-015 On an accepted go, the next edge SHALL load: dout=n, steps=0, peak=n, status=00.
REQ-016 On that same edge the state SHALL go to DONE with status 00 if n==1, to DONE with status 10 if n==0, else to RUN.
REQ-017 Each RUN cycle SHALL perform exactly one step: odd dout -> 3*dout+1; even dout -> dout>>1.
REQ-018 On each RUN step, steps SHALL increment and peak SHALL become max(peak, next value).
REQ-019 3*dout+1 SHALL be computed at WIDTH+2 bits; if the result exceeds 2^WIDTH-1, the block SHALL enter DONE with status 01.
REQ-020 On the overflow edge, dout, steps and peak SHALL hold their pre-step values.
REQ-021 When the next value equals 1, the block SHALL update dout, steps and peak, and enter DONE with status 00.
REQ-022 When steps equals 2^CNT_WIDTH-1 and the next value is not 1, the block SHALL enter DONE with status 11, with dout, steps and peak held; steps never wraps.
REQ-023 If overflow and step limit coincide, overflow (01) SHALL take priority.
REQ-024 Latency SHALL be k+1 cycles from the go edge to done for a run of k steps.
REQ-025 In DONE, all outputs SHALL hold until the next accepted go; a go in DONE restarts per REQ-015 with no idle cycle.
REQ-026 go held high continuously SHALL restart the block on every cycle it is in DONE.

Reset
REQ-027 Asserting reset SHALL immediately force: state=IDLE, dout=0, steps=0, peak=0, status=00, busy=0, done=0.
REQ-028 Reset mid-RUN SHALL abort the run with no residual state.
REQ-029 The first go after reset deasserts SHALL behave per REQ-015.

Configuration
REQ-030 With macro COLLATZ_PEAK_EN defined, the block SHALL track peak per REQ-011/REQ-018.
REQ-031 Without COLLATZ_PEAK_EN, peak SHALL be constant 0, no peak register or comparator SHALL be built, and all other behaviour SHALL be unchanged.

Verification
REQ-032 Nominal run: WIDTH=32, go with n=27 -> done after 112 cycles; dout=1, steps=111, peak=9232, status=00.
REQ-033 Trivial inputs: n=1 -> done next cycle, steps=0, status=00; n=0 -> done next cycle, dout=0, status=10.
REQ-034 Overflow: WIDTH=8, n=27 -> done with status=01, dout=107, steps=11, peak=214.
REQ-035 Step limit: CNT_WIDTH=4, WIDTH=32, n=27 -> done with status=11, steps=15.
REQ-036 go during RUN is ignored: n=27 run, go with n=6 at cycle 10 -> result unchanged from REQ-032.
REQ-037 Reset at cycle 50 of the n=27 run -> all outputs 0 immediately; a subsequent go with n=6 -> steps=8, peak=16, status=00.
REQ-038 A build without COLLATZ_PEAK_EN SHALL pass REQ-032 with peak=0.
